// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM encoding, funct3 size/sign codes and decode helpers.
// No logic of its own; imported by the LSU top and the load alignment block.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Everything the response path needs to recover the load result later.
    typedef struct packed {
        lsu_size_t  size;
        logic       uns;
        logic [1:0] lane;
    } ld_meta_t;

    // Unlisted codes fall through to a full-word access.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage and data-memory signal bundle of the load/store unit.
// slave = LSU view, master = execute stage plus memory environment.
interface load_store_unit_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              is_store;
    logic [2:0]        funct3;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DWIDTH-1:0] mem_rdata;

    logic [DWIDTH-1:0] DataR;
    logic              data_valid;
    logic              stall;
    logic              misaligned;

    modport slave (
        input  req_valid, is_store, funct3, addr, wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output DataR, data_valid, stall, misaligned
    );

    modport master (
        output req_valid, is_store, funct3, addr, wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  DataR, data_valid, stall, misaligned
    );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Picks the addressed byte/half out of a 32-bit read word and sign- or zero-extends it.
// Purely combinational, no backpressure.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  lsu_size_t   i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_lane)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            SZ_B:    o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_H:    o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time, IDLE -> REQ (until gnt) -> RESP (loads, until rvalid).
// Latency: store 2 cycles accept-to-data_valid, load 3, plus gnt/rvalid wait; stall holds the pipe.
// LSU_MISALIGN_TRAP_EN: trap misaligned H/W with a pulse instead of silently aligning the address.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave lsu
);

    lsu_state_t        r_state;
    logic              r_mem_req;
    logic              r_we;
    logic [3:0]        r_be;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_datar;
    logic              r_data_valid;
    ld_meta_t          r_ld;

    lsu_size_t         w_size;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [DWIDTH-1:0] w_wdata;
    logic [DWIDTH-1:0] w_ld_data;
    logic              w_idle;
    logic              w_issue;

    assign w_size = f3_size(lsu.funct3);
    assign w_idle = (r_state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_mis;
    logic r_misaligned;

    assign w_mis   = ((w_size == SZ_H) && lsu.addr[0]) ||
                     ((w_size == SZ_W) && (lsu.addr[1:0] != 2'b00));
    assign w_lane  = lsu.addr[1:0];
    assign w_issue = w_idle && lsu.req_valid && !w_mis;

    // A trapped op is consumed in IDLE: only the pulse, never a memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_idle && lsu.req_valid && w_mis;
        end
    end

    assign lsu.misaligned = r_misaligned;
`else
    // Force natural alignment so lane selection and byte enables stay consistent.
    assign w_lane  = (w_size == SZ_W) ? 2'b00 :
                     (w_size == SZ_H) ? {lsu.addr[1], 1'b0} : lsu.addr[1:0];
    assign w_issue = w_idle && lsu.req_valid;

    assign lsu.misaligned = 1'b0;
`endif

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = lsu.wdata;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{lsu.wdata[7:0]}};
            end
            SZ_H: begin
                w_be    = 4'b0011 << {w_lane[1], 1'b0};
                w_wdata = {2{lsu.wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = lsu.wdata;
            end
        endcase
    end

    load_align u_load_align (
        .i_rdata    (lsu.mem_rdata),
        .i_lane     (r_ld.lane),
        .i_size     (r_ld.size),
        .i_unsigned (r_ld.uns),
        .o_data     (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= 4'b0000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_datar      <= '0;
            r_data_valid <= 1'b0;
            r_ld         <= '0;
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state   <= REQ;
                        r_mem_req <= 1'b1;
                        r_we      <= lsu.is_store;
                        r_be      <= w_be;
                        r_addr    <= {lsu.addr[AWIDTH-1:2], 2'b00};
                        r_wdata   <= lsu.is_store ? w_wdata : '0;
                        r_ld      <= '{size: w_size, uns: f3_unsigned(lsu.funct3), lane: w_lane};
                    end
                end
                REQ: begin
                    // rvalid coinciding with gnt belongs to nothing we issued.
                    if (lsu.mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (r_we) begin
                            r_data_valid <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (lsu.mem_rvalid) begin
                        r_datar      <= w_ld_data;
                        r_data_valid <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign lsu.req_ready  = w_idle;
    assign lsu.stall      = !w_idle || lsu.req_valid;
    assign lsu.mem_req    = r_mem_req;
    assign lsu.mem_we     = r_we;
    assign lsu.mem_be     = r_be;
    assign lsu.mem_addr   = r_addr;
    assign lsu.mem_wdata  = r_wdata;
    assign lsu.DataR      = r_datar;
    assign lsu.data_valid = r_data_valid;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: driver pushes expected memory requests and responses,
// a negedge monitor pops and compares them as the DUT presents mem_gnt / data_valid.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    load_store_unit_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    load_store_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (bus)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rexp_t;

    mexp_t       mq[$];
    rexp_t       rq[$];
    int          cfg_gnt_dly = 0;
    int          cfg_rv_dly  = 0;
    logic        cfg_spur    = 1'b0;
    logic [31:0] cfg_rdata   = 32'h0;
    logic [31:0] last_load   = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: grants after cfg_gnt_dly REQ cycles, returns load data cfg_rv_dly cycles after RESP starts.
    initial begin : mem_model
        int   wcnt;
        int   rcnt;
        logic pend;
        wcnt = 0;
        rcnt = 0;
        pend = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
            if (pend) begin
                if (rcnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = cfg_rdata;
                    pend = 1'b0;
                end else begin
                    rcnt--;
                end
            end else if (bus.mem_req) begin
                if (wcnt >= cfg_gnt_dly) begin
                    bus.mem_gnt = 1'b1;
                    wcnt = 0;
                    if (!bus.mem_we) begin
                        pend = 1'b1;
                        rcnt = cfg_rv_dly;
                    end
                    if (cfg_spur) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = ~cfg_rdata;
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        rexp_t e;
        if (rst_n) begin
            if (!bus.req_ready) chk("stall_while_busy", 32'(bus.stall), 32'd1);
            if (bus.mem_req) begin
                chk("ready_while_req", 32'(bus.req_ready), 32'd0);
                if (mq.size() == 0) begin
                    chk("mem_req_unexpected", 32'(bus.mem_req), 32'd0);
                end else begin
                    chk("mem_we", 32'(bus.mem_we), 32'(mq[0].we));
                    chk("mem_be", 32'(bus.mem_be), 32'(mq[0].be));
                    chk("mem_addr", bus.mem_addr, mq[0].addr);
                    if (mq[0].we) chk("mem_wdata", bus.mem_wdata, mq[0].wdata);
                    if (bus.mem_gnt) void'(mq.pop_front());
                end
            end
            if (bus.data_valid) begin
                if (rq.size() == 0) begin
                    chk("data_valid_unexpected", 32'(bus.data_valid), 32'd0);
                end else begin
                    e = rq.pop_front();
                    chk("DataR", bus.DataR, e.data);
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
`ifndef LSU_MISALIGN_TRAP_EN
            if (bus.misaligned) chk("misaligned_tied_low", 32'(bus.misaligned), 32'd0);
`endif
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.req_ready) return;
        end
        chk("ready_timeout", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (rq.size() == 0 && mq.size() == 0) return;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout_resp", 32'(rq.size()), 32'd0);
        chk("drain_timeout_req", 32'(mq.size()), 32'd0);
        rq.delete();
        mq.delete();
    endtask

    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input int rd, input logic sp,
                         input logic [31:0] rdat, input logic [3:0] ebe, input logic [31:0] eaddr,
                         input logic [31:0] ewd, input logic [31:0] edata);
        mexp_t m;
        rexp_t r;
        int    lat;
        wait_ready();
        cfg_gnt_dly = gd;
        cfg_rv_dly  = rd;
        cfg_spur    = sp;
        cfg_rdata   = rdat;
        m.we = st; m.be = ebe; m.addr = eaddr; m.wdata = ewd;
        mq.push_back(m);
        lat = st ? (2 + gd) : (3 + gd + rd);
        if (!st) last_load = edata;
        r.data = last_load;
        r.cyc  = cyc + lat;
        rq.push_back(r);
        bus.is_store  = st;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.req_valid = 1'b1;
        #1;
        chk("stall_on_req_valid", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_drain();
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic mis_op(input logic st, input logic [2:0] f3, input logic [31:0] a);
        wait_ready();
        bus.is_store  = st;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = 32'h0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("mis_pulse", 32'(bus.misaligned), 32'd1);
        chk("mis_no_mem_req", 32'(bus.mem_req), 32'd0);
        chk("mis_stays_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mis_pulse_width", 32'(bus.misaligned), 32'd0);
        chk("mis_no_mem_req_after", 32'(bus.mem_req), 32'd0);
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.is_store  = 1'b0;
        bus.funct3    = 3'b000;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_DataR", bus.DataR, 32'h0);
        chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
        chk("rst_misaligned", 32'(bus.misaligned), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        rst_n = 1'b1;

        //    st  funct3  addr      wdata         gd rd sp rdata         be       maddr     mwdata        DataR
        do_op(0, F3_W,   32'h100, 32'h0,         0, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h100, 32'h0,         32'hDEADBEEF);
        do_op(0, F3_B,   32'h103, 32'h0,         0, 0, 0, 32'h80000000, 4'b1000, 32'h100, 32'h0,         32'hFFFFFF80);
        do_op(0, F3_BU,  32'h103, 32'h0,         0, 0, 0, 32'h80000000, 4'b1000, 32'h100, 32'h0,         32'h00000080);
        do_op(1, F3_H,   32'h102, 32'h1234ABCD,  0, 0, 0, 32'h0,        4'b1100, 32'h100, 32'hABCDABCD,  32'h0);
        do_op(1, F3_B,   32'h101, 32'h000000A5,  0, 0, 0, 32'h0,        4'b0010, 32'h100, 32'hA5A5A5A5,  32'h0);
        do_op(1, F3_W,   32'h104, 32'h11223344,  3, 0, 0, 32'h0,        4'b1111, 32'h104, 32'h11223344,  32'h0);
        do_op(0, F3_H,   32'h102, 32'h0,         1, 0, 0, 32'h80017FFF, 4'b1100, 32'h100, 32'h0,         32'hFFFF8001);
        do_op(0, F3_HU,  32'h100, 32'h0,         0, 0, 1, 32'h80017FFF, 4'b0011, 32'h100, 32'h0,         32'h00007FFF);
        do_op(0, F3_B,   32'h105, 32'h0,         2, 2, 0, 32'h12345678, 4'b0010, 32'h104, 32'h0,         32'h00000056);
        do_op(0, F3_BU,  32'h102, 32'h0,         0, 0, 0, 32'h00FE0000, 4'b0100, 32'h100, 32'h0,         32'h000000FE);
        do_op(0, 3'b011, 32'h108, 32'h0,         0, 0, 0, 32'hCAFEF00D, 4'b1111, 32'h108, 32'h0,         32'hCAFEF00D);
        do_op(1, 3'b111, 32'h10C, 32'h55AA33CC,  0, 0, 0, 32'h0,        4'b1111, 32'h10C, 32'h55AA33CC,  32'h0);
        do_op(0, F3_H,   32'h100, 32'h0,         0, 0, 0, 32'h00008000, 4'b0011, 32'h100, 32'h0,         32'hFFFF8000);
`ifdef LSU_MISALIGN_TRAP_EN
        mis_op(0, F3_W, 32'h101);
        mis_op(1, F3_H, 32'h103);
`else
        do_op(0, F3_W,   32'h101, 32'h0,         0, 0, 0, 32'h01020304, 4'b1111, 32'h100, 32'h0,         32'h01020304);
        do_op(1, F3_H,   32'h103, 32'h0000BEEF,  0, 0, 0, 32'h0,        4'b1100, 32'h100, 32'hBEEFBEEF,  32'h0);
`endif

        // Reset while a load sits in RESP; the late rvalid must be dropped.
        begin
            mexp_t m;
            wait_ready();
            cfg_gnt_dly = 0;
            cfg_rv_dly  = 4;
            cfg_spur    = 1'b0;
            cfg_rdata   = 32'h0BADF00D;
            m.we = 1'b0; m.be = 4'b1111; m.addr = 32'h110; m.wdata = 32'h0;
            mq.push_back(m);
            bus.is_store  = 1'b0;
            bus.funct3    = F3_W;
            bus.addr      = 32'h110;
            bus.req_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("resp_stall", 32'(bus.stall), 32'd1);
            #1;
            rst_n = 1'b0;
            #1;
            chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
            chk("midrst_DataR", bus.DataR, 32'h0);
            chk("midrst_ready", 32'(bus.req_ready), 32'd1);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            last_load = 32'h0;
            repeat (8) @(posedge clk);
            #1;
            chk("postrst_DataR", bus.DataR, 32'h0);
            chk("postrst_ready", 32'(bus.req_ready), 32'd1);
            chk("postrst_mem_req", 32'(bus.mem_req), 32'd0);
        end

        repeat (2) @(posedge clk);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        chk("req_queue_empty", 32'(mq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, meaning address width.
REQ-002 SHALL have parameter DWIDTH, default 32, meaning data width; only 32 supported.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  1  execute stage presents a memory op.
REQ-006 SHALL have port req_ready  output  1  unit idle and able to accept an op.
REQ-007 SHALL have port is_store  input  1  1 = store, 0 = load.
REQ-008 SHALL have port funct3  input  3  size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port addr  input  AWIDTH  byte address (alu_out).
REQ-010 SHALL have port wdata  input  DWIDTH  store data (rs2).
REQ-011 SHALL have ports mem_req, mem_we (output 1), mem_be (output 4), mem_addr (output AWIDTH, word-aligned), mem_wdata (output DWIDTH) for the data-memory request.
REQ-012 SHALL have ports mem_gnt (input 1, request accepted), mem_rvalid (input 1, read data valid) and mem_rdata (input DWIDTH).
REQ-013 SHALL have port DataR  output  DWIDTH  extended load result, feeds writeback mux DataR input.
REQ-014 SHALL have port data_valid  output  1  one-cycle pulse: DataR valid or store complete.
REQ-015 SHALL have port stall  output  1  pipeline hold while an op is in flight.
REQ-016 SHALL have port misaligned  output  1  one-cycle pulse on misaligned access (REQ-033).

Function
REQ-017 SHALL implement FSM states IDLE, REQ, RESP.
REQ-018 IDLE: req_ready=1; on req_valid SHALL register op fields and go to REQ next cycle.
REQ-019 REQ: SHALL hold mem_req=1 with stable mem_we/mem_be/mem_addr/mem_wdata until mem_gnt.
REQ-020 REQ with mem_gnt and store SHALL pulse data_valid next cycle and return to IDLE.
REQ-021 REQ with mem_gnt and load SHALL go to RESP; mem_rvalid in the same cycle as mem_gnt SHALL be ignored.
REQ-022 RESP with mem_rvalid SHALL register the extended DataR, pulse data_valid next cycle and return to IDLE.
REQ-023 mem_be SHALL be 0001<<addr[1:0] for byte, 0011<<(2*addr[1]) for half, 1111 for word.
REQ-024 mem_wdata SHALL replicate the byte (x4) or half (x2) across lanes; word passes through.
REQ-025 Loads SHALL select the lane from addr[1:0] and sign-extend (B, H) or zero-extend (BU, HU).
REQ-026 stall SHALL be 1 in REQ and RESP, and combinationally 1 in IDLE when req_valid=1.
REQ-027 DataR SHALL hold its last value until the next load completes.
REQ-028 Minimum latency SHALL be: store 2 cycles from accept to data_valid; load 3 cycles, given gnt and rvalid on first opportunity.
REQ-029 Undefined funct3 (011, 110, 111) SHALL be treated as word.

Reset
REQ-030 While rst_n=0: state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, DataR=0, data_valid=0, misaligned=0.
REQ-031 Reset mid-operation SHALL abandon the op with no data_valid; a late mem_rvalid after reset SHALL be ignored in IDLE.
REQ-032 Reset release SHALL take effect on the first rising clk edge with rst_n=1.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL pulse misaligned, issue no mem_req and stay in IDLE.
REQ-034 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned output SHALL be tied 0, and the offending low address bits SHALL be cleared (naturally aligned) before issue.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the funct3 size/sign constants.
REQ-036 Lane extract/extend SHALL be a combinational sub-module load_align.

Verification
REQ-037 Load W at 0x100, gnt and rvalid immediate, rdata 0xDEADBEEF -> DataR=0xDEADBEEF, data_valid 3 cycles after accept.
REQ-038 LB at 0x103, rdata 0x80000000 -> DataR=0xFFFFFF80; LBU -> 0x00000080.
REQ-039 SH at 0x102, wdata 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, data_valid after gnt.
REQ-040 mem_gnt delayed 3 cycles -> request signals stable, stall=1 throughout, single data_valid.
REQ-041 LW at 0x101 with LSU_MISALIGN_TRAP_EN -> misaligned pulse, no mem_req; without -> mem_addr=0x100.
REQ-042 rst_n low in RESP, then rvalid -> no data_valid, DataR=0, state IDLE.
